// File: rtl/uart_key_receiver.sv
// 8N1 UART receiver that shows each received byte on 'key' for a fixed hold window, then returns to 8'h00.
// The rx line is synchronised by two flops and every bit is sampled at its midpoint.
module uart_key_receiver #(
    parameter int CLKS_PER_BIT    = 564,
    parameter int KEY_HOLD_CYCLES = 1_300_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int HW = $clog2(KEY_HOLD_CYCLES + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(KEY_HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    r_data;
    logic [7:0]    w_data_next;
    logic          w_load;
    logic          w_frame_err;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_key;
    logic          r_key_valid;
    logic          r_frame_err;

    // NOTE: the synchroniser resets to the idle-high level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // NOTE: state is updated only with non-blocking assignments; all next values come from the comb block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_idx <= w_bit_idx_next;
            r_data    <= w_data_next;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_idx_next = r_bit_idx;
        w_data_next    = r_data;
        w_load         = 1'b0;
        w_frame_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_timer_next = '0;
                end
            end
            S_START: begin
                if (r_timer == HALF_LAST) begin
                    w_timer_next = '0;
                    if (r_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = '0;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_DATA: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_next = '0;
                    w_data_next  = {r_rx_s, r_data[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_STOP: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_next = '0;
                    if (r_rx_s) begin
                        w_load       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_BREAK: begin
                // A line held low stays here so it cannot start a new frame.
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A load takes priority over hold expiry, so a byte arriving on the expiry cycle is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_key       <= 8'h00;
            r_key_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_key_valid <= w_load;
            r_frame_err <= w_frame_err;
            if (w_load) begin
                r_key  <= r_data;
                r_hold <= HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HW'(1);
                if (r_hold == HW'(1)) begin
                    r_key <= 8'h00;
                end
            end
        end
    end

    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign frame_err = r_frame_err;

endmodule
